cola_buyer: RTL
===============

Name: cola_buyer

Overview:
Customer-side initiator for the coin/cola vending handshake. On a purchase request it emits a programmed number of single-cycle coin pulses on po_money, spaced by a fixed gap. It counts the cola pulses returned by the vending FSM, then reports completion with the cola count. It drives the vending FSM's pi_money input and monitors its po_cola output, and serves as both a board-level stimulus source and a bench driver.

Parameters:
CNT_W, 4, width of coin_num and cola_cnt.
GAP_CYC, 4, idle cycles between consecutive coin pulses; legal range 1..15.
TAIL_CYC, 2, cycles after the last coin pulse during which returned cola pulses are still counted; legal range 1..15.

Ports:
sys_clk  input  1  system clock, rising edge.
sys_rst_n  input  1  reset, asynchronous, active-low.
buy_req  input  1  start pulse; sampled only in IDLE.
coin_num  input  CNT_W  number of coins to insert; latched with buy_req.
po_money  output  1  coin pulse to vending FSM, one cycle wide.
pi_cola  input  1  cola pulse from vending FSM.
busy  output  1  high from the cycle after the accepting edge through the DONE cycle.
done  output  1  one-cycle completion pulse.
cola_cnt  output  CNT_W  colas received in the current/last transaction; valid when done=1, held until the next accept.

Behaviour:
- Reset values: po_money=0, busy=0, done=0, cola_cnt=0, state=IDLE, internal counters=0.
- Reset mid-transaction aborts immediately to IDLE with all outputs 0. No partial pulse is allowed after reset deasserts.
- State encoding is one-hot: IDLE, SEND, GAP, TAIL, DONE. All outputs are registered.
- IDLE:
  - On buy_req=1, latch coin_num into remain and clear cola_cnt.
  - If coin_num==0, go to DONE; otherwise go to SEND.
  - buy_req in any other state is ignored; there is no queueing.
- SEND (1 cycle):
  - po_money=1; remain decrements.
  - If the decremented remain is 0, go to TAIL; otherwise go to GAP.
- GAP: po_money=0 for exactly GAP_CYC cycles, then go to SEND.
- TAIL: exactly TAIL_CYC cycles, then go to DONE.
- DONE (1 cycle): done=1, busy=1, then go to IDLE. busy=0 in IDLE.
- Timing, with the accepting edge at cycle 0 and N≥1 coins:
  - Coin pulse k (k=0..N-1) is high in cycle 1+k·(GAP_CYC+1).
  - The DONE cycle is 1+(N-1)(GAP_CYC+1)+TAIL_CYC+1.
  - For N=0, DONE is in cycle 1.
- Cola counting:
  - Every cycle with pi_cola=1 in SEND, GAP or TAIL increments cola_cnt.
  - cola_cnt saturates at 2^CNT_W-1.
  - pi_cola in IDLE or DONE is ignored.
- The vending FSM asserts po_cola in the cycle after the third coin, so TAIL_CYC≥1 guarantees the final cola is captured.
- Back-to-back use: buy_req may be accepted in the first IDLE cycle after DONE.

Decomposition:
- Shared package holds:
  - State one-hot constants: ST_IDLE=5'b00001, ST_SEND=5'b00010, ST_GAP=5'b00100, ST_TAIL=5'b01000, ST_DONE=5'b10000.
  - Defaults for GAP_CYC and TAIL_CYC.
- One sub-module is natural: cyc_timer. It is a loadable 4-bit down-counter with a zero flag and is reused for both the GAP and TAIL intervals. The rest is a single FSM plus counters.

Test Plan:
1. Reset: hold sys_rst_n=0 for 3 cycles, release -> po_money=0, busy=0, done=0, cola_cnt=0. A buy_req during reset is never acted on.
2. coin_num=3, default params, connected to the vending FSM -> po_money high in cycles 1, 6, 11; vending FSM emits po_cola in cycle 12; done in cycle 14 with cola_cnt=1.
3. coin_num=7 with the vending FSM -> 7 pulses at a 5-cycle period; done with cola_cnt=2. The vending FSM is left in state ONE after one unused coin.
4. coin_num=0 -> done in cycle 1, busy high only in cycle 1, cola_cnt=0, no po_money pulse.
5. Second buy_req (coin_num=9) asserted mid-transaction of coin_num=3 -> ignored; exactly 3 pulses. A buy_req in the cycle after DONE starts a new transaction with cola_cnt cleared.
6. Assert sys_rst_n=0 in a GAP cycle after pulse 2 of 5 -> outputs clear in the same cycle; after release, no further pulses and the block is idle until buy_req.

Source files
------------

// File: rtl/cola_buyer_pkg.sv
// ==========================================================================
// cola_buyer_pkg : one-hot states and interval defaults for cola_buyer. Rev 1.0
// ==========================================================================
`default_nettype none

package cola_buyer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_SEND = 5'b00010,
    ST_GAP  = 5'b00100,
    ST_TAIL = 5'b01000,
    ST_DONE = 5'b10000
  } state_t;

  localparam int GAP_CYC_DEF  = 4;
  localparam int TAIL_CYC_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/cola_buyer_cyc_timer.sv
// ==========================================================================
// cola_buyer_cyc_timer : loadable 4-bit down-counter with zero flag. Rev 1.0
// ==========================================================================
`default_nettype none

module cola_buyer_cyc_timer (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/cola_buyer.sv
// ==========================================================================
// cola_buyer : emits coin pulses to the vending FSM and counts returned colas. Rev 1.0
// ==========================================================================
`default_nettype none

module cola_buyer
  import cola_buyer_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int TAIL_CYC = TAIL_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             buy_req,
  input  logic [CNT_W-1:0] coin_num,
  output logic             po_money,
  input  logic             pi_cola,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cola_cnt
);

  localparam logic [3:0] GAP_LD  = 4'(GAP_CYC - 1);
  localparam logic [3:0] TAIL_LD = 4'(TAIL_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] remain, remain_nx, remain_dec;
  logic             accept;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [3:0]       tmr_val;
  logic             counting;

  assign remain_dec = remain - CNT_W'(1);
  assign counting   = (state == ST_SEND) || (state == ST_GAP) || (state == ST_TAIL);

  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    accept    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = 4'd0;
    tmr_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (buy_req) begin
          accept    = 1'b1;
          remain_nx = coin_num;
          state_nx  = (coin_num == '0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        remain_nx = remain_dec;
        tmr_load  = 1'b1;
        if (remain_dec == '0) begin
          tmr_val  = TAIL_LD;
          state_nx = ST_TAIL;
        end else begin
          tmr_val  = GAP_LD;
          state_nx = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_zero) state_nx = ST_SEND;
        else          tmr_en   = 1'b1;
      end
      ST_TAIL: begin
        if (tmr_zero) state_nx = ST_DONE;
        else          tmr_en   = 1'b1;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      remain   <= '0;
      po_money <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cola_cnt <= '0;
    end else begin
      state    <= state_nx;
      remain   <= remain_nx;
      po_money <= (state_nx == ST_SEND);
      busy     <= (state_nx != ST_IDLE);
      done     <= (state_nx == ST_DONE);
      if (accept) begin
        cola_cnt <= '0;
      end else if (counting && pi_cola && (cola_cnt != '1)) begin
        cola_cnt <= cola_cnt + CNT_W'(1);
      end
    end
  end

  cola_buyer_cyc_timer u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .en        (tmr_en),
    .zero      (tmr_zero)
  );

endmodule

`default_nettype wire
